// File: rtl/ram_pkg.sv
// Shared data-memory parameters and word type.
// The CPU register file and bus reuse these definitions.
package ram_pkg;

  localparam int RAM_DATA_W = 16;
  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;

  typedef logic [RAM_DATA_W-1:0] ram_word_t;
  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;

endpackage

// File: rtl/ram.sv
// Single-port data memory: synchronous write, registered write-first read.
// The array is built from flops with an asynchronous clear because the CPU relies on zeroed memory after reset.
module ram
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  output logic [DATA_W-1:0] dout
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // No handshake: every rising edge is a transaction. we=1 writes din to
  // mem[addr] and returns din on dout; we=0 returns mem[addr] on dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      dout <= '0;
    end else if (we) begin
      mem[addr] <= din;
      dout      <= din;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed literal checks plus randomized
// traffic compared every cycle against a behavioural memory model.
module tb_ram;
  import ram_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] din   = '0;
  logic [7:0]  addr  = '0;
  logic        we    = 1'b0;
  logic [15:0] dout;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_mem [256];
  logic [15:0] exp_q [$];

  ram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .addr  (addr),
    .we    (we),
    .dout  (dout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an array of words; each edge yields one expected read value.
  // An empty queue means a reset happened since the last edge, so 0 is due.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (model_mem[i]) model_mem[i] = 16'h0000;
      exp_q.delete();
    end else if (we) begin
      model_mem[addr] = din;
      exp_q.push_back(din);
    end else begin
      exp_q.push_back(model_mem[addr]);
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
    check("model_dout", dout, e);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic w, input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    we   = w;
    addr = a;
    din  = d;
  endtask

  task automatic expect_lit(input string name, input logic [15:0] val);
    @(posedge clk);
    #1;
    check(name, dout, val);
  endtask

  // Reset pulse between edges; optionally held across one rising edge.
  task automatic pulse_reset(input bit hold_edge);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_immediate", dout, 16'h0000);
    if (hold_edge) begin
      @(posedge clk);
      #1;
      check("rst_held_edge", dout, 16'h0000);
    end
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] v;
    #1;
    rst_n = 1'b0;
    we    = 1'b1;
    din   = 16'hFFFF;
    addr  = 8'h05;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_hold", dout, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    we    = 1'b0;
    drive(1'b0, 8'h05, 16'h0000); expect_lit("rst_addr5", 16'h0000);

    // write-first, hold
    drive(1'b1, 8'h00, 16'hA00A); expect_lit("write_first", 16'hA00A);
    drive(1'b0, 8'h00, 16'h400A); expect_lit("hold_1", 16'hA00A);
    drive(1'b0, 8'h00, 16'h400A); expect_lit("hold_2", 16'hA00A);

    // unwritten location
    drive(1'b0, 8'h01, 16'h9C04); expect_lit("unwritten", 16'h0000);
    drive(1'b1, 8'h01, 16'h9C04); expect_lit("write_1", 16'h9C04);

    // overwrite
    drive(1'b1, 8'h00, 16'hE00A); expect_lit("ovw_0", 16'hE00A);
    drive(1'b1, 8'h01, 16'h8000); expect_lit("ovw_1", 16'h8000);
    drive(1'b0, 8'h00, 16'h0000); expect_lit("rd_0", 16'hE00A);
    drive(1'b0, 8'h01, 16'h0000); expect_lit("rd_1", 16'h8000);

    // full sweep including 8'hFF
    for (int i = 0; i < 256; i++) begin
      v = 16'(i) ^ 16'h5A5A;
      drive(1'b1, 8'(i), v);
    end
    for (int i = 0; i < 256; i++) begin
      v = 16'(i) ^ 16'h5A5A;
      drive(1'b0, 8'(i), 16'(i));
      expect_lit("sweep", v);
    end

    // reset mid-operation, with a write pending across the held edge
    drive(1'b1, 8'h0A, 16'h1111);
    drive(1'b1, 8'h0B, 16'h2222);
    drive(1'b1, 8'h0C, 16'h3333);
    drive(1'b1, 8'h14, 16'hBEEF);
    pulse_reset(1'b1);
    drive(1'b0, 8'h14, 16'h0000); expect_lit("lost_write", 16'h0000);
    drive(1'b0, 8'h0A, 16'h0000); expect_lit("clr_0a", 16'h0000);
    drive(1'b0, 8'h0B, 16'h0000); expect_lit("clr_0b", 16'h0000);
    drive(1'b0, 8'hFF, 16'h0000); expect_lit("clr_ff", 16'h0000);

    // short reset pulse strictly between edges
    drive(1'b1, 8'h33, 16'h7777);
    @(posedge clk);
    pulse_reset(1'b0);
    drive(1'b0, 8'h33, 16'h0000); expect_lit("clr_33", 16'h0000);

    // randomized traffic over a small window to force address reuse
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
      if ($urandom_range(0, 149) == 0) begin
        pulse_reset(1'($urandom_range(0, 1)));
      end
    end
    drive(1'b0, 8'h00, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
